regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised CPU register file: two async read ports, one sync write port with enable, write-to-read
//  bypass, hardwired zero register, and a per-register busy scoreboard for pending writes (e.g. loads).
//  Sits between decode (reads and reservations) and writeback (writes) in the microprocessor datapath.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and data port
//  ADDR_WIDTH  5   register index width
//  NUM_REGS    32  implemented registers, 2..2**ADDR_WIDTH; indices >= NUM_REGS are out of range
//  ZERO_REG    1   1: register 0 reads 0, ignores writes/reservations; 0: register 0 is ordinary
//  BYPASS      1   1: same-cycle write data forwarded to matching read port; 0: read sees stored value
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  read_register_1  in   ADDR_WIDTH  read port 1 index
//  read_register_2  in   ADDR_WIDTH  read port 2 index
//  read_data_1      out  DATA_WIDTH  port 1 data (combinational)
//  read_data_2      out  DATA_WIDTH  port 2 data (combinational)
//  read_valid_1     out  1           port 1 data not pending (combinational)
//  read_valid_2     out  1           port 2 data not pending (combinational)
//  write_enable     in   1           commit write_data to write_register on clock edge
//  write_register   in   ADDR_WIDTH  write index
//  write_data       in   DATA_WIDTH  write value
//  reserve_enable   in   1           mark reserve_register busy on clock edge
//  reserve_register in   ADDR_WIDTH  index to reserve
//  busy_count       out  ADDR_WIDTH+1 number of busy registers (registered)
// BEHAVIOUR
//  - Reset (async, any time): all registers <= 0, all busy bits <= 0, busy_count <= 0. Read outputs are then
//    0 with valid=1 for in-range indices. Reset mid-write discards the write.
//  - Write: on rising edge with write_enable=1 and index writable, reg[write_register] <= write_data and busy
//    bit cleared. Not writable: index >= NUM_REGS, or index 0 when ZERO_REG=1 (silently ignored).
//  - Reserve: on rising edge with reserve_enable=1 and index writable, busy bit set. Reserve and write to the
//    same index in the same cycle: data written AND busy bit left set (reservation is the newer instruction).
//    Reserve of an already-busy register: stays busy, count unchanged.
//  - Read (per port, combinational, zero latency):
//      index out of range        -> data 0, valid 0
//      index 0 and ZERO_REG=1    -> data 0, valid 1
//      BYPASS=1, write_enable=1, write_register==index, writable -> data write_data, valid 1
//      otherwise                 -> data reg[index], valid !busy[index]
//    Bypass ignores same-cycle reserve (reservation takes effect next cycle). Both ports may read same index.
//  - busy_count: registered popcount of busy bits, updated same edge as bits; range 0..NUM_REGS (no wrap).
//  - All state updates are on the rising edge only; no X on outputs for any in/out-of-range input.
// TESTING
//  1 Reset then read r0/r5 -> data 0, valid 1; busy_count 0. Write r1=1 -> next cycle read_data_1=1.
//  2 Write r0=2 (ZERO_REG=1) -> r0 still reads 0; ZERO_REG=0 build -> r0 reads 2.
//  3 BYPASS: write_enable, r2=6 while read_register_1=2 -> read_data_1=6 same cycle; BYPASS=0 -> old 0.
//  4 Reserve r3 -> read_valid_1=0, busy_count=1; write r3=7 -> valid 1, data 7, busy_count 0;
//    reserve+write r3=9 same cycle -> data 9, valid 0, busy_count 1.
//  5 NUM_REGS=8: read r12 -> data 0, valid 0; write r12 ignored; reserve r12 -> busy_count unchanged.
//  6 Reserve r1,r2,r4 then assert reset between edges -> immediately busy_count 0, all reads 0/valid 1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   CPU register file with two combinational read ports and one synchronous
//   write port. Same-cycle write data can be forwarded to the read ports. It
//   can hardwire register 0 to zero. It also keeps a per-register busy
//   scoreboard for writes that have been issued but not yet written back.
//
// Ports
//   clock, reset                        rising-edge clock, async active-high reset
//   read_register_{1,2}                 read indices
//   read_data_{1,2}, read_valid_{1,2}   combinational read data and not-pending flag
//   write_enable/register/data          writeback port
//   reserve_enable/register             decode-side reservation (sets busy)
//   busy_count                          registered popcount of the busy bits
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_valid_1,
  output logic                  read_valid_2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_register,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam logic [ADDR_WIDTH:0] NREGS = (ADDR_WIDTH+1)'(NUM_REGS);

  // The extra top bit keeps the compare meaningful when NUM_REGS == 2**ADDR_WIDTH.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] idx);
    return {1'b0, idx} < NREGS;
  endfunction

  function automatic logic f_writable(input logic [ADDR_WIDTH-1:0] idx);
    return f_in_range(idx) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                 r_busy;
  logic [ADDR_WIDTH:0]                 r_busy_count;

  logic                w_wr_ok;
  logic                w_rsv_ok;
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_rsv_hit;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_WIDTH:0] w_cnt_nxt;

  assign w_wr_ok  = write_enable   && f_writable(write_register);
  assign w_rsv_ok = reserve_enable && f_writable(reserve_register);

  // A reservation wins over a same-cycle write to the same register. The write
  // retires an older instruction, and the reservation belongs to a newer one
  // that still owns the result.
  always_comb begin
    w_wr_hit   = '0;
    w_rsv_hit  = '0;
    w_busy_nxt = '0;
    w_cnt_nxt  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_hit[i]   = w_wr_ok  && (write_register   == ADDR_WIDTH'(i));
      w_rsv_hit[i]  = w_rsv_ok && (reserve_register == ADDR_WIDTH'(i));
      w_busy_nxt[i] = (r_busy[i] && !w_wr_hit[i]) || w_rsv_hit[i];
      w_cnt_nxt     = w_cnt_nxt + (ADDR_WIDTH+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_regs       <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_wr_hit[i]) r_regs[i] <= write_data;
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_cnt_nxt;
    end
  end

  assign busy_count = r_busy_count;

  logic [1:0][ADDR_WIDTH-1:0] w_rd_idx;
  assign w_rd_idx[0] = read_register_1;
  assign w_rd_idx[1] = read_register_2;

  // Both read ports are identical. Each mux is a compare loop, so an
  // out-of-range index never indexes the storage.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_vld;
    always_comb begin
      w_data = '0;
      w_vld  = 1'b0;
      if (!f_in_range(w_rd_idx[p])) begin
        w_data = '0;
        w_vld  = 1'b0;
      end else if ((ZERO_REG != 0) && (w_rd_idx[p] == '0)) begin
        w_data = '0;
        w_vld  = 1'b1;
      end else if ((BYPASS != 0) && w_wr_ok && (write_register == w_rd_idx[p])) begin
        // The forwarded value is final even if a reserve is pending this
        // cycle. That reserve only marks the register busy after the edge.
        w_data = write_data;
        w_vld  = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_rd_idx[p] == ADDR_WIDTH'(i)) begin
            w_data = r_regs[i];
            w_vld  = !r_busy[i];
          end
        end
      end
    end
  end

  assign read_data_1  = g_rd[0].w_data;
  assign read_valid_1 = g_rd[0].w_vld;
  assign read_data_2  = g_rd[1].w_data;
  assign read_valid_2 = g_rd[1].w_vld;

endmodule
